generic_bus_ahb_master: RTL and testbench
=========================================

# generic_bus_ahb_master

Converts the memory controller's single arbitrated outbound generic bus into an AHB-Lite master interface toward the system interconnect. It registers stalled address phases, pipelines one outstanding data phase behind an accepted address phase, and completes each transfer back to the memory controller with a one-cycle busy-low strobe. It derives transfer size and low address bits from byte enables.

## Interface
- HPROT_VAL, 4'b0011: constant driven on HPROT (data access, privileged, non-bufferable, non-cacheable).
- HBURST_VAL, 3'b000: constant driven on HBURST (SINGLE).
- CLK  input  1  clock, all state on rising edge.
- nRST  input  1  reset, asynchronous, active-low.
- addr  input  32  generic bus request address (word-aligned; low bits ignored).
- wdata  input  32  generic bus write data, valid with wen.
- ren  input  1  read request.
- wen  input  1  write request (ren and wen never both high).
- byte_en  input  4  active byte lanes; lane i = HWDATA/HRDATA[8i+7:8i].
- rdata  output  32  read data, equal to HRDATA, valid when busy low.
- busy  output  1  low for exactly one cycle when a transfer's data phase completes.
- bus_err  output  1  high together with busy low when the completing transfer got an ERROR response.
- HADDR  output  32  AHB address.
- HWRITE  output  1  AHB write.
- HTRANS  output  2  IDLE (2'b00) or NONSEQ (2'b10) only.
- HSIZE  output  3  AHB size.
- HBURST  output  3  = HBURST_VAL.
- HPROT  output  4  = HPROT_VAL.
- HMASTLOCK  output  1  constant 0.
- HWDATA  output  32  write data for the current data phase.
- HRDATA  input  32  read data.
- HREADY  input  1  transfer-done / address-accept.
- HRESP  input  1  0 OKAY, 1 ERROR.

## Operation
- Request offered: (ren|wen) high in a cycle. The requester may drop it after one cycle, or may hold it until busy goes low. The block must issue it exactly once in both cases.
- Address source:
  - If hold_valid, drive the address phase from the hold register and ignore ren/wen.
  - Else drive it combinationally from the inputs.
  - HTRANS = NONSEQ when hold_valid or ren|wen; otherwise IDLE.
- Acceptance: HTRANS = NONSEQ && HREADY.
  - On acceptance: set data_pending, latch HWRITE into dp_write, latch wdata into HWDATA, clear hold_valid.
- Stall: an offered but not accepted request with hold_valid = 0 loads the hold register {addr, wdata, wen, byte_en} and sets hold_valid.
- At most one data phase is outstanding.
  - Completion: data_pending && HREADY. busy = 0 that cycle, rdata = HRDATA, bus_err = HRESP.
  - data_pending clears at completion unless a new acceptance happens in the same cycle, in which case it stays set.
- ERROR: the first cycle (HREADY=0, HRESP=1) is a normal stall. Completion occurs on the second cycle. A held address phase is not cancelled and continues to be driven.
- HSIZE/HADDR[1:0] from byte_en:
  - 1111 → size 2, offset 0.
  - 0011 → size 1, offset 0.
  - 1100 → size 1, offset 2.
  - One-hot lane i → size 0, offset i.
  - Any other pattern → size 2, offset 0.
  - HADDR = {addr[31:2], offset}.
- States (encoded by hold_valid, data_pending):
  - IDLE (0,0).
  - ADDR_HOLD (1,0).
  - DATA (0,1).
  - DATA_HOLD (1,1): address held while the previous data phase is still outstanding.

## Timing
- Reset values: HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, busy=1, bus_err=0, rdata=HRDATA, hold_valid=0, data_pending=0.
- Minimum latency: request in cycle N with HREADY=1 gives address phase in N and busy low in N+1 if the slave has zero wait states. Each slave wait state adds one cycle.
- Back-to-back transfers: a new request offered in the completion cycle is accepted that same cycle. Its busy-low strobe comes no earlier than the next cycle.
- busy and bus_err are combinational from HREADY/HRESP/data_pending. All other state is registered.
- HWDATA changes only on acceptance and stays stable through the whole data phase.
- Reset mid-transfer drops the hold and pending state immediately. No completion strobe is produced.

## Test plan
- Single read, addr 0x1000_0004, byte_en 1111, zero-wait slave returning 0xDEADBEEF → HTRANS NONSEQ, HSIZE 2 in cycle N; busy=0, rdata=0xDEADBEEF in N+1; busy=1 afterwards.
- Byte write, byte_en 0100, addr 0x2000_0000, wdata 0x00AB0000, HREADY low 3 cycles in data phase → HADDR 0x2000_0002, HSIZE 0; HWDATA stable 4 cycles; exactly one busy-low cycle.
- One-cycle ren pulse while HREADY=0 for 2 cycles (other master) → hold register drives NONSEQ the same address for 3 cycles; exactly one acceptance; one busy-low strobe.
- Read pending with 2 wait states while a write is offered and held → write accepted in the read's completion cycle; two busy-low strobes on consecutive or later cycles; no duplicate NONSEQ.
- Slave ERROR (HREADY 0/HRESP 1, then 1/1) → busy=0 and bus_err=1 in the second cycle only; next request proceeds normally.
- Assert nRST during DATA_HOLD → all outputs return to reset values asynchronously; no busy-low strobe after release.

Source files
------------

// File: rtl/generic_bus_ahb_master.sv
// Generic-bus to AHB-Lite master bridge: one held address phase plus one outstanding data phase,
// with a single-cycle busy-low completion strobe back to the memory controller.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no held address, no data phase outstanding
// ST_ADDR    | address phase held in the hold register, waiting for HREADY
// ST_DATA    | one data phase outstanding, no held address
// ST_DHOLD   | data phase outstanding and the next address phase held
module generic_bus_ahb_master #(
    parameter logic [3:0] HPROT_VAL  = 4'b0011,
    parameter logic [2:0] HBURST_VAL = 3'b000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        ren,
    input  logic        wen,
    input  logic [3:0]  byte_en,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        bus_err,
    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ADDR  = 2'b10;
    localparam logic [1:0] ST_DATA  = 2'b01;
    localparam logic [1:0] ST_DHOLD = 2'b11;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    logic [1:0]  state, state_nxt;
    logic        hold_valid, data_pending;

    logic [29:0] hold_addr;
    logic [31:0] hold_wdata;
    logic        hold_write;
    logic [3:0]  hold_be;

    // req_taken masks a request the requester keeps high after it was captured;
    // taken_in_dp says that captured request is the one now in its data phase.
    logic        req_taken;
    logic        taken_in_dp;

    logic        req_any, in_req, nonseq, accept, complete, stall_load;
    logic [29:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_write;
    logic [3:0]  sel_be;
    logic [2:0]  size;
    logic [1:0]  offset;

    logic        unused_addr_lsb;
    assign unused_addr_lsb = ^addr[1:0];

    assign hold_valid   = state[1];
    assign data_pending = state[0];

    assign req_any    = ren | wen;
    assign in_req     = req_any & ~req_taken & nRST;
    assign nonseq     = hold_valid | in_req;
    assign accept     = nonseq & HREADY;
    assign complete   = data_pending & HREADY;
    assign stall_load = in_req & ~hold_valid & ~HREADY;

    assign sel_addr  = hold_valid ? hold_addr  : addr[31:2];
    assign sel_wdata = hold_valid ? hold_wdata : wdata;
    assign sel_write = hold_valid ? hold_write : wen;
    assign sel_be    = hold_valid ? hold_be    : byte_en;

    always_comb begin
        size   = 3'd2;
        offset = 2'd0;
        case (sel_be)
            4'b0011: size = 3'd1;
            4'b1100: begin size = 3'd1; offset = 2'd2; end
            4'b0001: begin size = 3'd0; offset = 2'd0; end
            4'b0010: begin size = 3'd0; offset = 2'd1; end
            4'b0100: begin size = 3'd0; offset = 2'd2; end
            4'b1000: begin size = 3'd0; offset = 2'd3; end
            default: ;
        endcase
    end

    assign HTRANS    = nonseq ? TRANS_NONSEQ : TRANS_IDLE;
    assign HADDR     = nonseq ? {sel_addr, offset} : 32'h0;
    assign HWRITE    = nonseq & sel_write;
    assign HSIZE     = nonseq ? size : 3'd0;
    assign HBURST    = HBURST_VAL;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;

    assign rdata   = HRDATA;
    assign busy    = ~complete;
    assign bus_err = complete & HRESP;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept)          state_nxt = ST_DATA;
                else if (stall_load) state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                if (HREADY) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (accept)          state_nxt = ST_DATA;
                else if (stall_load) state_nxt = ST_DHOLD;
                else if (complete)   state_nxt = ST_IDLE;
            end
            ST_DHOLD: begin
                // completion and acceptance of the held address share the same HREADY
                if (HREADY) state_nxt = ST_DATA;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hold_addr  <= 30'h0;
            hold_wdata <= 32'h0;
            hold_write <= 1'b0;
            hold_be    <= 4'h0;
        end else if (stall_load) begin
            hold_addr  <= addr[31:2];
            hold_wdata <= wdata;
            hold_write <= wen;
            hold_be    <= byte_en;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            HWDATA <= 32'h0;
        end else if (accept) begin
            HWDATA <= sel_wdata;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            req_taken   <= 1'b0;
            taken_in_dp <= 1'b0;
        end else begin
            if (!req_any)                      req_taken <= 1'b0;
            else if (in_req && !hold_valid)    req_taken <= 1'b1;
            else if (taken_in_dp && complete)  req_taken <= 1'b0;

            if (accept)          taken_in_dp <= 1'b1;
            else if (stall_load) taken_in_dp <= 1'b0;
            else if (complete)   taken_in_dp <= 1'b0;
        end
    end

endmodule

// File: tb/tb_generic_bus_ahb_master.sv
// Self-checking bench for generic_bus_ahb_master: directed scenarios and random traffic, both
// checked every cycle against a transaction-level model built from queues.
module tb_generic_bus_ahb_master;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] addr, wdata, rdata, HADDR, HWDATA, HRDATA;
    logic        ren, wen, busy, bus_err, HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [3:0]  byte_en, HPROT;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;

    always #5 CLK = ~CLK;

    generic_bus_ahb_master dut (
        .CLK(CLK), .nRST(nRST), .addr(addr), .wdata(wdata), .ren(ren), .wen(wen),
        .byte_en(byte_en), .rdata(rdata), .busy(busy), .bus_err(bus_err),
        .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          id;
    } req_t;

    req_t        await_q[$];   // issued, address phase not yet accepted
    req_t        infl_q[$];    // accepted, data phase not yet completed
    req_t        cur;
    bit          cur_active, cur_captured, cur_hold, prev_active;
    logic        s_ready, s_resp;
    logic [31:0] rd_val;
    int          checks, failures, accepts, strobes, issued, next_id;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // AHB size and low address bits implied by the byte lanes
    function automatic logic [4:0] size_off(input logic [3:0] be);
        int n;
        n = $countones(be);
        if (n == 1) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) return {3'd0, 2'(i)};
        end
        if (be == 4'b0011) return {3'd1, 2'd0};
        if (be == 4'b1100) return {3'd1, 2'd2};
        return {3'd2, 2'd0};
    endfunction

    task automatic start_req(input logic [31:0] a, input logic we, input logic [3:0] be,
                             input logic [31:0] wd, input bit hold);
        cur = '{a, we, be, wd, next_id};
        next_id++;
        issued++;
        cur_active   = 1'b1;
        cur_captured = 1'b0;
        cur_hold     = hold;
    endtask

    // One bus cycle: drive at posedge+1, check at posedge+4, advance the model, return at next posedge+1.
    task automatic cycle();
        bit          new_off, exp_ns, dp, release_req, was_active;
        req_t        src, done;
        logic [4:0]  so;
        was_active = cur_active;
        ren = cur_active && !cur.we;
        wen = cur_active && cur.we;
        if (cur_active) begin
            addr = cur.addr; wdata = cur.wdata; byte_en = cur.be;
        end else begin
            addr = $urandom; wdata = $urandom; byte_en = 4'($urandom_range(0, 15));
        end
        HREADY = s_ready;
        HRESP  = s_resp;
        HRDATA = rd_val;
        #3;
        new_off = cur_active && !cur_captured && (await_q.size() == 0);
        exp_ns  = (await_q.size() != 0) || new_off;
        src     = (await_q.size() != 0) ? await_q[0] : cur;
        chk("htrans", 32'(HTRANS), exp_ns ? 32'd2 : 32'd0);
        if (exp_ns) begin
            so = size_off(src.be);
            chk("haddr", HADDR, {src.addr[31:2], so[1:0]});
            chk("hsize", 32'(HSIZE), 32'(so[4:2]));
            chk("hwrite", 32'(HWRITE), 32'(src.we));
        end
        dp = (infl_q.size() != 0);
        chk("busy", 32'(busy), 32'(!(dp && s_ready)));
        chk("bus_err", 32'(bus_err), 32'(dp && s_ready && s_resp));
        if (dp) chk("hwdata", HWDATA, infl_q[0].wdata);
        release_req = 1'b0;
        if (dp && s_ready) begin
            chk("rdata", rdata, rd_val);
            done = infl_q.pop_front();
            strobes++;
            if (cur_active && cur_hold && done.id == cur.id) release_req = 1'b1;
        end
        if (exp_ns && s_ready) begin
            if (await_q.size() != 0) infl_q.push_back(await_q.pop_front());
            else begin infl_q.push_back(cur); cur_captured = 1'b1; end
            accepts++;
        end else if (new_off) begin
            await_q.push_back(cur);
            cur_captured = 1'b1;
        end
        if (cur_active && !cur_hold) cur_active = 1'b0;
        if (release_req) cur_active = 1'b0;
        prev_active = was_active;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            s_ready = 1'b1; s_resp = 1'b0; rd_val = $urandom;
            cycle();
        end
    endtask

    initial begin
        int s0, a0, err_stage;
        checks = 0; failures = 0; accepts = 0; strobes = 0; issued = 0; next_id = 0;
        cur_active = 0; cur_captured = 0; cur_hold = 0; prev_active = 0;
        cur = '{32'h0, 1'b0, 4'h0, 32'h0, -1};
        nRST = 1'b0; ren = 0; wen = 0; addr = 0; wdata = 0; byte_en = 0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h1234_5678;
        s_ready = 1'b1; s_resp = 1'b0; rd_val = 32'h0;
        #2;
        chk("rst_htrans", 32'(HTRANS), 32'd0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwrite", 32'(HWRITE), 32'd0);
        chk("rst_hsize", 32'(HSIZE), 32'd0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_rdata", rdata, 32'h1234_5678);
        chk("hprot", 32'(HPROT), 32'h3);
        chk("hburst", 32'(HBURST), 32'h0);
        chk("hmastlock", 32'(HMASTLOCK), 32'h0);
        @(posedge CLK); @(posedge CLK); #1;
        nRST = 1'b1;
        idle_cycles(2);

        // single zero-wait read
        s0 = strobes;
        start_req(32'h1000_0004, 1'b0, 4'b1111, 32'h0, 1'b0);
        s_ready = 1; s_resp = 0; rd_val = 32'h0; cycle();
        rd_val = 32'hDEAD_BEEF; cycle();
        idle_cycles(2);
        chk("t1_strobes", 32'(strobes - s0), 32'd1);

        // byte write, requester holds, three wait states in the data phase
        s0 = strobes;
        start_req(32'h2000_0000, 1'b1, 4'b0100, 32'h00AB_0000, 1'b1);
        s_ready = 1; cycle();
        for (int i = 0; i < 3; i++) begin s_ready = 0; cycle(); end
        s_ready = 1; cycle();
        idle_cycles(2);
        chk("t2_strobes", 32'(strobes - s0), 32'd1);

        // one-cycle pulse while another master holds HREADY low
        s0 = strobes; a0 = accepts;
        start_req(32'h3000_0010, 1'b0, 4'b0011, 32'h0, 1'b0);
        s_ready = 0; cycle();
        s_ready = 0; cycle();
        s_ready = 1; cycle();
        idle_cycles(2);
        chk("t3_accepts", 32'(accepts - a0), 32'd1);
        chk("t3_strobes", 32'(strobes - s0), 32'd1);

        // read with two wait states, write offered and held meanwhile
        s0 = strobes; a0 = accepts;
        start_req(32'h4000_0008, 1'b0, 4'b1111, 32'h0, 1'b0);
        s_ready = 1; cycle();
        s_ready = 0; cycle();
        start_req(32'h4000_0100, 1'b1, 4'b1000, 32'h5500_0000, 1'b0);
        s_ready = 0; cycle();
        s_ready = 1; rd_val = 32'hCAFE_0001; cycle();
        idle_cycles(2);
        chk("t4_accepts", 32'(accepts - a0), 32'd2);
        chk("t4_strobes", 32'(strobes - s0), 32'd2);

        // ERROR response, then a normal read
        start_req(32'h5000_0000, 1'b0, 4'b1111, 32'h0, 1'b0);
        s_ready = 1; s_resp = 0; cycle();
        s_ready = 0; s_resp = 1; cycle();
        s_ready = 1; s_resp = 1; cycle();
        s_resp = 0;
        idle_cycles(1);
        start_req(32'h5000_0004, 1'b0, 4'b1100, 32'h0, 1'b0);
        idle_cycles(3);

        // reset while a data phase is outstanding and the next address is held
        start_req(32'h6000_0000, 1'b0, 4'b1111, 32'h0, 1'b0);
        s_ready = 1; cycle();
        s_ready = 0; cycle();
        start_req(32'h6000_0040, 1'b1, 4'b0001, 32'h0000_0077, 1'b0);
        s_ready = 0; cycle();
        HREADY = 1'b1; ren = 1'b0; wen = 1'b0;
        #1 nRST = 1'b0;
        #1;
        chk("rst2_htrans", 32'(HTRANS), 32'd0);
        chk("rst2_haddr", HADDR, 32'h0);
        chk("rst2_hwrite", 32'(HWRITE), 32'd0);
        chk("rst2_hsize", 32'(HSIZE), 32'd0);
        chk("rst2_hwdata", HWDATA, 32'h0);
        chk("rst2_busy", 32'(busy), 32'd1);
        chk("rst2_bus_err", 32'(bus_err), 32'd0);
        await_q.delete(); infl_q.delete();
        cur_active = 0; prev_active = 0;
        accepts = strobes; issued = strobes;
        @(posedge CLK); #1;
        nRST = 1'b1;
        s0 = strobes;
        idle_cycles(4);
        chk("t6_no_strobe", 32'(strobes - s0), 32'd0);

        // random traffic
        err_stage = 0;
        for (int c = 0; c < 1500; c++) begin
            if (!cur_active && !prev_active && await_q.size() == 0 && $urandom_range(0, 2) == 0)
                start_req($urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          $urandom, 1'($urandom_range(0, 1)));
            if (err_stage != 0) begin
                s_ready = 1; s_resp = 1; err_stage = 0;
            end else if (infl_q.size() != 0 && $urandom_range(0, 9) == 0) begin
                s_ready = 0; s_resp = 1; err_stage = 1;
            end else begin
                s_ready = ($urandom_range(0, 3) != 0); s_resp = 0;
            end
            rd_val = $urandom;
            cycle();
        end
        for (int i = 0; i < 60 && (cur_active || await_q.size() != 0 || infl_q.size() != 0); i++) begin
            s_ready = 1; s_resp = 0; rd_val = $urandom;
            cycle();
        end
        chk("drained", 32'(await_q.size() + infl_q.size()), 32'd0);
        chk("issued_once", 32'(accepts), 32'(issued));
        chk("all_completed", 32'(strobes), 32'(issued));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
